// File: rtl/ascon_pack.sv
// Shared ASCON package: word-serializer geometry constants and FSM state type.
// Contents:
//   SER_DATA_W / SER_WORD_W / SER_NWORDS - default serializer geometry
//   ser_state_t                          - serializer FSM state encoding
package ascon_pack;

  localparam int unsigned SER_DATA_W = 128;
  localparam int unsigned SER_WORD_W = 32;
  localparam int unsigned SER_NWORDS = SER_DATA_W / SER_WORD_W;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_t;

endpackage : ascon_pack

// File: rtl/ascon_word_counter.sv
// Modulo-NWORDS word index counter with enable and terminal-count flag.
// Ports:
//   clock_i  - system clock, rising edge
//   reset_i  - synchronous active-high reset (count returns to 0)
//   en_i     - advance the count by one (wraps to 0 from NWORDS-1)
//   count_o  - current index, $clog2(NWORDS) bits
//   tc_o     - count_o == NWORDS-1
module ascon_word_counter #(
  parameter int unsigned NWORDS = 4,
  parameter int unsigned CNT_W  = $clog2(NWORDS)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             tc;

  assign tc = (count_q == CNT_W'(NWORDS - 1));

  // Next count: wrap on the terminal value so the index never exceeds NWORDS-1.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = tc ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc;

endmodule : ascon_word_counter

// File: rtl/ascon_word_serializer128.sv
// Serializes a DATA_W-bit value into DATA_W/WORD_W words, MSB word first,
// over a valid/ready handshake.
// Ports:
//   clock_i       - system clock, rising edge
//   reset_i       - synchronous active-high reset; aborts any transfer
//   load_i/data_i - capture request and parallel value (taken only when idle)
//   load_ready_o  - idle and able to accept a load
//   word_o        - current output word
//   valid_o       - word_o valid
//   ready_i       - downstream accepts word_o
//   last_o        - word_o is the final word of the block (qualified by valid_o)
//   done_o        - one-cycle pulse after the final word is accepted
// Build option:
//   ASCON_SERIALIZER_ZEROIZE_EN - clear the store after the final handshake and
//                                 force word_o to 0 while not valid.
module ascon_word_serializer128
  import ascon_pack::*;
#(
  parameter int unsigned DATA_W = SER_DATA_W,
  parameter int unsigned WORD_W = SER_WORD_W
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              load_ready_o,
  output logic [WORD_W-1:0] word_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              done_o
);

  localparam int unsigned NWORDS = DATA_W / WORD_W;
  localparam int unsigned CNT_W  = $clog2(NWORDS);

  ser_state_t                     state_q, state_d;
  logic [NWORDS-1:0][WORD_W-1:0]  store_q, store_d;
  logic                           done_q, done_d;

  logic [CNT_W-1:0] index;
  logic             index_tc;
  logic             cnt_en;
  logic             handshake;
  logic             final_hs;
  logic [WORD_W-1:0] word_sel;

  // Word index; only advances on accepted words, so it is 0 whenever idle.
  ascon_word_counter #(
    .NWORDS (NWORDS),
    .CNT_W  (CNT_W)
  ) u_word_counter (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .en_i    (cnt_en),
    .count_o (index),
    .tc_o    (index_tc)
  );

  assign handshake = (state_q == SER_SEND) && ready_i;
  assign final_hs  = handshake && index_tc;

  // State register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= SER_IDLE;
      store_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SER_IDLE: if (load_i)   state_d = SER_SEND;
      SER_SEND: if (final_hs) state_d = SER_IDLE;
      default:                state_d = SER_IDLE;
    endcase
  end

  // Output / datapath control decoded from the registered state.
  always_comb begin
    load_ready_o = 1'b0;
    valid_o      = 1'b0;
    cnt_en       = 1'b0;
    done_d       = 1'b0;
    store_d      = store_q;
    unique case (state_q)
      SER_IDLE: begin
        load_ready_o = 1'b1;
        if (load_i) store_d = data_i;
      end
      SER_SEND: begin
        valid_o = 1'b1;
        cnt_en  = ready_i;
        done_d  = final_hs;
`ifdef ASCON_SERIALIZER_ZEROIZE_EN
        if (final_hs) store_d = '0;
`endif
      end
      default: ;
    endcase
  end

  // Word 0 is the most significant slice of the store.
  assign word_sel = store_q[CNT_W'(NWORDS - 1) - index];

`ifdef ASCON_SERIALIZER_ZEROIZE_EN
  assign word_o = valid_o ? word_sel : '0;
`else
  assign word_o = word_sel;
`endif

  assign last_o = valid_o && index_tc;
  assign done_o = done_q;

endmodule : ascon_word_serializer128

// File: tb/tb_ascon_word_serializer128.sv
// Directed self-checking bench for ascon_word_serializer128 (128-bit in, 32-bit words).
module tb_ascon_word_serializer128;

  logic         clock_i = 1'b0;
  logic         reset_i;
  logic         load_i;
  logic [127:0] data_i;
  logic         load_ready_o;
  logic [31:0]  word_o;
  logic         valid_o;
  logic         ready_i;
  logic         last_o;
  logic         done_o;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] DATA_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] DATA_D = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
  localparam logic [127:0] DATA_B = 128'h0BADF00D_CAFEBABE_13579BDF_2468ACE0;

  ascon_word_serializer128 dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .load_i       (load_i),
    .data_i       (data_i),
    .load_ready_o (load_ready_o),
    .word_o       (word_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .last_o       (last_o),
    .done_o       (done_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  function automatic logic [31:0] wsel(input logic [127:0] d, input int i);
    logic [127:0] t;
    t = d << (i * 32);
    return t[127:96];
  endfunction

  // Check the remaining words from index `from` with ready_i=1, then the done cycle.
  task automatic drain(input string tag, input logic [127:0] d, input int from);
    ready_i = 1'b1;
    for (int i = from; i < 4; i++) begin
      chk({tag, "_valid"}, 128'(valid_o), 128'(1'b1));
      chk({tag, "_word"},  128'(word_o),  128'(wsel(d, i)));
      chk({tag, "_last"},  128'(last_o),  128'(i == 3));
      chk({tag, "_lrdy"},  128'(load_ready_o), 128'(1'b0));
      chk({tag, "_done0"}, 128'(done_o),  128'(1'b0));
      step();
    end
    chk({tag, "_done"},    128'(done_o),  128'(1'b1));
    chk({tag, "_lrdy_end"}, 128'(load_ready_o), 128'(1'b1));
    chk({tag, "_vld_end"}, 128'(valid_o), 128'(1'b0));
  endtask

  initial begin
    reset_i = 1'b1;
    load_i  = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    @(negedge clock_i);
    step();
    step();
    reset_i = 1'b0;

    // Reset state.
    chk("rst_valid", 128'(valid_o), 128'(1'b0));
    chk("rst_last",  128'(last_o),  128'(1'b0));
    chk("rst_done",  128'(done_o),  128'(1'b0));
    chk("rst_lrdy",  128'(load_ready_o), 128'(1'b1));
    chk("rst_word",  128'(word_o),  128'(32'h0));

    // Basic transfer.
    data_i = DATA_A; load_i = 1'b1; ready_i = 1'b1;
    step();
    load_i = 1'b0; data_i = '0;
    drain("basic", DATA_A, 0);
`ifdef ASCON_SERIALIZER_ZEROIZE_EN
    chk("zero_word",  128'(word_o), 128'(32'h0));
    chk("zero_store", 128'(dut.store_q), 128'h0);
`else
    chk("idle_word",  128'(word_o), 128'(32'h00112233));
`endif
    step();
    chk("basic_done_pulse", 128'(done_o), 128'(1'b0));

    // Backpressure while word 2 is presented.
    data_i = DATA_A; load_i = 1'b1;
    step();
    load_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp_pre_word", 128'(word_o), 128'(wsel(DATA_A, i)));
      step();
    end
    ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("bp_stall_word",  128'(word_o),  128'(32'h8899AABB));
      chk("bp_stall_valid", 128'(valid_o), 128'(1'b1));
      chk("bp_stall_last",  128'(last_o),  128'(1'b0));
      step();
    end
    chk("bp_stall_done", 128'(done_o), 128'(1'b0));
    drain("bp", DATA_A, 2);
    step();

    // Load request during SEND is ignored.
    data_i = DATA_A; load_i = 1'b1;
    step();
    load_i = 1'b0;
    chk("ls_w0", 128'(word_o), 128'(32'h00112233));
    step();
    load_i = 1'b1; data_i = '1;
    chk("ls_lrdy", 128'(load_ready_o), 128'(1'b0));
    chk("ls_w1",   128'(word_o), 128'(32'h44556677));
    step();
    load_i = 1'b0;
    drain("ls", DATA_A, 2);
    load_i = 1'b1; data_i = '1;
    step();
    load_i = 1'b0;
    drain("ls_next", '1, 0);
    step();

    // Reset mid-transfer after word 2 has been accepted.
    data_i = DATA_A; load_i = 1'b1;
    step();
    load_i = 1'b0;
    step();
    step();
    chk("rm_w2", 128'(word_o), 128'(32'h8899AABB));
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("rm_valid", 128'(valid_o), 128'(1'b0));
    chk("rm_lrdy",  128'(load_ready_o), 128'(1'b1));
    chk("rm_done",  128'(done_o), 128'(1'b0));
    chk("rm_word",  128'(word_o), 128'(32'h0));
    step();
    chk("rm_done2", 128'(done_o), 128'(1'b0));
    chk("rm_valid2", 128'(valid_o), 128'(1'b0));
    data_i = DATA_D; load_i = 1'b1;
    step();
    load_i = 1'b0;
    drain("rm_fresh", DATA_D, 0);
    step();

    // Back-to-back blocks: second load in the done cycle, one idle cycle between.
    data_i = DATA_A; load_i = 1'b1;
    step();
    load_i = 1'b0;
    drain("b2b_a", DATA_A, 0);
    data_i = DATA_B; load_i = 1'b1;
    step();
    load_i = 1'b0;
    drain("b2b_b", DATA_B, 0);
    step();
    chk("b2b_end_done", 128'(done_o), 128'(1'b0));

    // ready_i in IDLE is ignored.
    ready_i = 1'b1;
    step();
    chk("idle_ready_valid", 128'(valid_o), 128'(1'b0));
    chk("idle_ready_lrdy",  128'(load_ready_o), 128'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ascon_word_serializer128
